// File: rtl/avalon_st_pkg.sv
// Shared helpers for the Avalon-ST data format adapters: width arithmetic
// and the adapter state encoding.
package avalon_st_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } adapter_state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((32'sd1 <<< result) < value) begin
      result = result + 32'sd1;
    end
    return result;
  endfunction

  // A zero-width empty field is not legal, so one-symbol streams still get a bit.
  function automatic int empty_width(input int symbols);
    return (clog2(symbols) > 32'sd0) ? clog2(symbols) : 32'sd1;
  endfunction

  function automatic int data_width(input int symbols, input int bits_per_symbol);
    return symbols * bits_per_symbol;
  endfunction

  function automatic bit is_pow2(input int value);
    return (value > 32'sd0) && ((value & (value - 32'sd1)) == 32'sd0);
  endfunction

endpackage

// File: rtl/avalon_st_data_format_downsizer.sv
// Splits each wide Avalon-ST beat into RATIO narrow beats, MSB slice first,
// trimming the trailing beats that would carry only empty symbols.
module avalon_st_data_format_downsizer
  import avalon_st_pkg::*;
#(
  parameter int IN_SYMBOLS      = 8,
  parameter int OUT_SYMBOLS     = 4,
  parameter int BITS_PER_SYMBOL = 8
) (
  input  logic                                              clk,
  input  logic                                              reset,
  output logic                                              in_ready,
  input  logic                                              in_valid,
  input  logic [data_width(IN_SYMBOLS, BITS_PER_SYMBOL)-1:0]  in_data,
  input  logic                                              in_startofpacket,
  input  logic                                              in_endofpacket,
  input  logic [empty_width(IN_SYMBOLS)-1:0]                in_empty,
  input  logic                                              out_ready,
  output logic                                              out_valid,
  output logic [data_width(OUT_SYMBOLS, BITS_PER_SYMBOL)-1:0] out_data,
  output logic                                              out_startofpacket,
  output logic                                              out_endofpacket,
  output logic [empty_width(OUT_SYMBOLS)-1:0]               out_empty
);

  localparam int RATIO  = IN_SYMBOLS / OUT_SYMBOLS;
  localparam int IN_W   = data_width(IN_SYMBOLS, BITS_PER_SYMBOL);
  localparam int OUT_W  = data_width(OUT_SYMBOLS, BITS_PER_SYMBOL);
  localparam int IN_EW  = empty_width(IN_SYMBOLS);
  localparam int OUT_EW = empty_width(OUT_SYMBOLS);
  localparam int IDX_W  = empty_width(RATIO);
  localparam int VW     = clog2(IN_SYMBOLS) + 1;

  if (!is_pow2(RATIO) || (RATIO < 2) || ((RATIO * OUT_SYMBOLS) != IN_SYMBOLS)) begin : g_ratio_check
    $error("IN_SYMBOLS/OUT_SYMBOLS must be an integer power of two >= 2");
  end

  adapter_state_e   state_r;
  adapter_state_e   state_nxt_s;
  logic [IDX_W-1:0] idx_r;
  logic [IDX_W-1:0] idx_nxt_s;
  logic             load_s;
  logic [IN_W-1:0]  hold_data_r;
  logic             hold_sop_r;
  logic             hold_eop_r;
  logic [IN_EW-1:0] hold_empty_r;

  logic [VW-1:0]     valid_syms_s;
  logic [IDX_W-1:0]  last_idx_s;
  logic [OUT_EW-1:0] last_empty_s;
  logic              busy_s;
  logic              last_s;
  logic [OUT_W-1:0]  hold_slices_s [RATIO];

  for (genvar g = 0; g < RATIO; g++) begin : g_slice
    assign hold_slices_s[g] = hold_data_r[IN_W-1-g*OUT_W -: OUT_W];
  end

  // Beat count and last-beat empty derived from the held word's valid symbols.
  always_comb begin
    if (hold_eop_r) begin
      valid_syms_s = VW'(IN_SYMBOLS) - VW'(hold_empty_r);
    end else begin
      valid_syms_s = VW'(IN_SYMBOLS);
    end
    last_idx_s   = IDX_W'((valid_syms_s - VW'(1)) / VW'(OUT_SYMBOLS));
    last_empty_s = OUT_EW'(((VW'(last_idx_s) + VW'(1)) * VW'(OUT_SYMBOLS)) - valid_syms_s);
    busy_s       = (state_r == ST_BUSY);
    last_s       = busy_s && (idx_r == last_idx_s);
  end

  // Output beat presentation; in_ready may follow out_ready combinationally.
  always_comb begin
    out_valid         = busy_s;
    out_data          = hold_slices_s[idx_r];
    out_startofpacket = busy_s && hold_sop_r && (idx_r == IDX_W'(0));
    out_endofpacket   = last_s && hold_eop_r;
    if (last_s && hold_eop_r) begin
      out_empty = last_empty_s;
    end else begin
      out_empty = OUT_EW'(0);
    end
    in_ready = (state_r == ST_IDLE) || (last_s && out_ready);
  end

  // Next-state logic: step through slices, reload on the last accepted beat.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    load_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          load_s      = 1'b1;
          state_nxt_s = ST_BUSY;
          idx_nxt_s   = IDX_W'(0);
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (out_ready) begin
          if (last_s) begin
            idx_nxt_s = IDX_W'(0);
            if (in_valid) begin
              load_s      = 1'b1;
              state_nxt_s = ST_BUSY;
            end else begin
              state_nxt_s = ST_IDLE;
            end
          end else begin
            idx_nxt_s = idx_r + IDX_W'(1);
          end
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        idx_nxt_s   = IDX_W'(0);
      end
    endcase
  end

  // State and slice index registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      idx_r   <= IDX_W'(0);
    end else begin
      state_r <= state_nxt_s;
      idx_r   <= idx_nxt_s;
    end
  end

  // Holding register for the accepted wide beat and its framing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_data_r  <= IN_W'(0);
      hold_sop_r   <= 1'b0;
      hold_eop_r   <= 1'b0;
      hold_empty_r <= IN_EW'(0);
    end else if (load_s) begin
      hold_data_r  <= in_data;
      hold_sop_r   <= in_startofpacket;
      hold_eop_r   <= in_endofpacket;
      hold_empty_r <= in_empty;
    end else begin
      hold_data_r  <= hold_data_r;
      hold_sop_r   <= hold_sop_r;
      hold_eop_r   <= hold_eop_r;
      hold_empty_r <= hold_empty_r;
    end
  end

endmodule

// File: tb/tb_avalon_st_data_format_downsizer.sv
// Self-checking bench for the 64->32 bit Avalon-ST downsizer: directed cases
// followed by randomized packets under backpressure against a queue model.
module tb_avalon_st_data_format_downsizer;

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [1:0]  empty;
  } beat_t;

  typedef struct packed {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [2:0]  empty;
  } word_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_ready;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = 64'd0;
  logic        in_startofpacket = 1'b0;
  logic        in_endofpacket = 1'b0;
  logic [2:0]  in_empty = 3'd0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_startofpacket;
  logic        out_endofpacket;
  logic [1:0]  out_empty;

  int          checks = 0;
  int          errors = 0;
  int          obs_sop = 0;
  int          obs_eop = 0;
  beat_t       exp_q[$];
  word_t       src_q[$];
  bit          use_model = 1'b0;
  bit          stalled = 1'b0;
  logic [36:0] held_out = 37'd0;

  avalon_st_data_format_downsizer dut (
    .clk               (clk),
    .reset             (reset),
    .in_ready          (in_ready),
    .in_valid          (in_valid),
    .in_data           (in_data),
    .in_startofpacket  (in_startofpacket),
    .in_endofpacket    (in_endofpacket),
    .in_empty          (in_empty),
    .out_ready         (out_ready),
    .out_valid         (out_valid),
    .out_data          (out_data),
    .out_startofpacket (out_startofpacket),
    .out_endofpacket   (out_endofpacket),
    .out_empty         (out_empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic word_t mk(input logic [63:0] d, input logic s, input logic e, input logic [2:0] emp);
    word_t w;
    w.data = d; w.sop = s; w.eop = e; w.empty = emp;
    return w;
  endfunction

  function automatic beat_t bt(input logic [31:0] d, input logic s, input logic e, input logic [1:0] emp);
    beat_t b;
    b.data = d; b.sop = s; b.eop = e; b.empty = emp;
    return b;
  endfunction

  // Reference: split a wide word into ceil(valid/4) narrow beats, MSB half first.
  task automatic push_model(input word_t w);
    int          v;
    int          n;
    logic [63:0] sh;
    beat_t       b;
    v = w.eop ? 8 - int'(w.empty) : 8;
    n = (v + 3) / 4;
    for (int k = 0; k < n; k++) begin
      sh      = w.data >> (32 * (1 - k));
      b.data  = sh[31:0];
      b.sop   = w.sop && (k == 0);
      b.eop   = w.eop && (k == n - 1);
      b.empty = (w.eop && (k == n - 1)) ? 2'(n * 4 - v) : 2'd0;
      exp_q.push_back(b);
    end
  endtask

  task automatic drive(input logic v, input word_t w, input logic ordy);
    in_valid         = v;
    in_data          = w.data;
    in_startofpacket = w.sop;
    in_endofpacket   = w.eop;
    in_empty         = w.empty;
    out_ready        = ordy;
  endtask

  // One clock cycle: sample away from the edge, score handshakes, advance.
  task automatic tick(output logic rdy, output logic ofire);
    beat_t cur;
    beat_t e;
    #1;
    rdy      = in_ready;
    ofire    = out_valid && out_ready;
    cur.data = out_data; cur.sop = out_startofpacket;
    cur.eop  = out_endofpacket; cur.empty = out_empty;
    if (stalled) check("stall_stable", 64'({out_valid, cur}), 64'(held_out));
    if (ofire) begin
      if (cur.sop) obs_sop++;
      if (cur.eop) obs_eop++;
      check("beat_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("beat_data", 64'(cur.data), 64'(e.data));
        check("beat_flags", 64'({cur.sop, cur.eop, cur.empty}), 64'({e.sop, e.eop, e.empty}));
      end
    end
    stalled  = out_valid && !out_ready;
    held_out = {out_valid, cur};
    if (in_valid && in_ready && use_model)
      push_model(mk(in_data, in_startofpacket, in_endofpacket, in_empty));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_one(input word_t w);
    logic r, f;
    drive(1'b1, w, 1'b1);
    tick(r, f);
    check("send_accepted", 64'(r), 64'd1);
    drive(1'b0, mk(64'd0, 1'b0, 1'b0, 3'd0), 1'b1);
  endtask

  task automatic drain(input string tag);
    logic r, f;
    int   cnt;
    cnt = 0;
    drive(1'b0, mk(64'd0, 1'b0, 1'b0, 3'd0), 1'b1);
    while (exp_q.size() > 0 && cnt < 20) begin
      tick(r, f);
      cnt++;
    end
    check(tag, 64'(exp_q.size()), 64'd0);
    check({tag, "_idle"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    logic  r, f;
    int    wi;
    int    cyc;
    int    len;
    word_t words[4];

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_flags", 64'({out_startofpacket, out_endofpacket, out_empty}), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Single non-eop beat
    exp_q.push_back(bt(32'h00112233, 1'b1, 1'b0, 2'd0));
    exp_q.push_back(bt(32'h44556677, 1'b0, 1'b0, 2'd0));
    send_one(mk(64'h0011223344556677, 1'b1, 1'b0, 3'd0));
    drain("t1_drain");

    // Eop with empty=5: one beat, ready for the next word in the same cycle
    exp_q.push_back(bt(32'h8899AABB, 1'b1, 1'b1, 2'd1));
    send_one(mk(64'h8899AABBCCDDEEFF, 1'b1, 1'b1, 3'd5));
    tick(r, f);
    check("t2_out_fire", 64'(f), 64'd1);
    check("t2_in_ready_same_cycle", 64'(r), 64'd1);
    drain("t2_drain");

    // Eop with empty=0 and empty=3
    exp_q.push_back(bt(32'h11223344, 1'b1, 1'b0, 2'd0));
    exp_q.push_back(bt(32'h55667788, 1'b0, 1'b1, 2'd0));
    send_one(mk(64'h1122334455667788, 1'b1, 1'b1, 3'd0));
    drain("t3a_drain");
    exp_q.push_back(bt(32'hA1A2A3A4, 1'b1, 1'b0, 2'd0));
    exp_q.push_back(bt(32'hA5A6A7A8, 1'b0, 1'b1, 2'd3));
    send_one(mk(64'hA1A2A3A4A5A6A7A8, 1'b1, 1'b1, 3'd3));
    drain("t3b_drain");

    // Back-to-back 4-beat packet, in_valid held, no backpressure
    use_model = 1'b1;
    for (int i = 0; i < 4; i++)
      words[i] = mk({$urandom, $urandom}, i == 0, i == 3, 3'd0);
    wi = 0;
    for (int c = 0; c < 9; c++) begin
      if (wi < 4) drive(1'b1, words[wi], 1'b1);
      else        drive(1'b0, mk(64'd0, 1'b0, 1'b0, 3'd0), 1'b1);
      tick(r, f);
      if (c < 8)  check($sformatf("b2b_in_ready_%0d", c), 64'(r), 64'(c % 2 == 0));
      if (c >= 1) check($sformatf("b2b_out_fire_%0d", c), 64'(f), 64'd1);
      if (in_valid && r) wi++;
    end
    check("b2b_words_taken", 64'(wi), 64'd4);
    drain("b2b_drain");

    // Randomized packets with 50% output backpressure
    for (int p = 0; p < 1000; p++) begin
      len = $urandom_range(1, 4);
      for (int b = 0; b < len; b++)
        src_q.push_back(mk({$urandom, $urandom}, b == 0, b == len - 1, 3'($urandom_range(0, 7))));
    end
    obs_sop = 0;
    obs_eop = 0;
    cyc = 0;
    while ((src_q.size() > 0 || exp_q.size() > 0) && cyc < 60000) begin
      if (src_q.size() > 0 && $urandom_range(0, 3) != 0)
        drive(1'b1, src_q[0], 1'($urandom_range(0, 1)));
      else
        drive(1'b0, mk(64'd0, 1'b0, 1'b0, 3'd0), 1'($urandom_range(0, 1)));
      tick(r, f);
      if (in_valid && r) void'(src_q.pop_front());
      cyc++;
    end
    check("rand_completed", 64'(src_q.size() + exp_q.size()), 64'd0);
    check("rand_sop_count", 64'(obs_sop), 64'd1000);
    check("rand_eop_count", 64'(obs_eop), 64'd1000);
    drain("rand_drain");

    // Reset while the second slice is pending
    use_model = 1'b0;
    exp_q.push_back(bt(32'h01020304, 1'b1, 1'b0, 2'd0));
    send_one(mk(64'h0102030405060708, 1'b1, 1'b0, 3'd0));
    tick(r, f);
    check("pre_reset_fire", 64'(f), 64'd1);
    check("pre_reset_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b0;
    reset = 1'b1;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_out_data", 64'(out_data), 64'd0);
    check("midrst_flags", 64'({out_startofpacket, out_endofpacket, out_empty}), 64'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    stalled = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("postrst_no_beat", 64'(out_valid), 64'd0);
    exp_q.push_back(bt(32'hDEADBEEF, 1'b1, 1'b0, 2'd0));
    exp_q.push_back(bt(32'hCAFEF00D, 1'b0, 1'b1, 2'd0));
    send_one(mk(64'hDEADBEEFCAFEF00D, 1'b1, 1'b1, 3'd0));
    drain("postrst_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
